// File: rtl/four_xor.sv
// Registered four-operand XOR tree: E = A^B, F = C^D, G = E^F, with a
// one-cycle valid pipeline. Lanes are bitwise independent.
module four_xor #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic             out_valid,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G
);

    logic [WIDTH-1:0] e_next_c;
    logic [WIDTH-1:0] f_next_c;
    logic [WIDTH-1:0] g_next_c;

    // G is built from the pair results so G == E ^ F holds by construction
    always_comb begin
        e_next_c = A ^ B;
        f_next_c = C ^ D;
        g_next_c = e_next_c ^ f_next_c;
    end

    // Results only move on a valid capture; X on idle inputs never reaches state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            E         <= '0;
            F         <= '0;
            G         <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                E <= e_next_c;
                F <= f_next_c;
                G <= g_next_c;
            end
        end
    end

endmodule

// File: tb/tb_four_xor.sv
// Directed bench for four_xor: one WIDTH=1 instance for the exhaustive,
// reset, hold and latency scenarios, one WIDTH=4 instance for lane checks.
module tb_four_xor;

    logic       clk;
    logic       rst_n;

    logic       in_valid1;
    logic       a1, b1, c1, d1;
    logic       out_valid1;
    logic       e1, f1, g1;

    logic       in_valid4;
    logic [3:0] a4, b4, c4, d4;
    logic       out_valid4;
    logic [3:0] e4, f4, g4;

    int n_vec;
    int n_err;

    four_xor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
        .A(a1), .B(b1), .C(c1), .D(d1),
        .out_valid(out_valid1), .E(e1), .F(f1), .G(g1)
    );

    four_xor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4),
        .A(a4), .B(b4), .C(c4), .D(d4),
        .out_valid(out_valid4), .E(e4), .F(f4), .G(g4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set1(input logic [3:0] abcd, input logic v);
        a1 = abcd[3]; b1 = abcd[2]; c1 = abcd[1]; d1 = abcd[0];
        in_valid1 = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set1(4'b0000, 1'b0);
        in_valid4 = 1'b0;
        a4 = '0; b4 = '0; c4 = '0; d4 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_w1: got ov/E/F/G=%b expected 0000", {out_valid1, e1, f1, g1});
        end
        n_vec++;
        if ({out_valid4, e4, f4, g4} !== 13'b0) begin
            n_err++;
            $display("FAIL reset_w4: got ov=%b E=%h F=%h G=%h expected all 0", out_valid4, e4, f4, g4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // A toggles every cycle, B every 2, C every 4, D every 8; all back-to-back
    task automatic test_sweep;
        logic [15:0] e_tab, f_tab, g_tab;
        e_tab = 16'h6666;
        f_tab = 16'h0FF0;
        g_tab = 16'h6996;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            a1 = i[0]; b1 = i[1]; c1 = i[2]; d1 = i[3];
            in_valid1 = 1'b1;
            @(posedge clk);
            #1;
            n_vec++;
            if ({out_valid1, e1, f1, g1} !== {1'b1, e_tab[i], f_tab[i], g_tab[i]}) begin
                n_err++;
                $display("FAIL sweep[%0d]: got ov/E/F/G=%b expected %b", i,
                         {out_valid1, e1, f1, g1}, {1'b1, e_tab[i], f_tab[i], g_tab[i]});
            end
        end
        @(negedge clk);
        set1(4'b1011, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        if ({e1, f1, g1} !== 3'b101) begin
            n_err++;
            $display("FAIL sweep_1011: got E/F/G=%b expected 101", {e1, f1, g1});
        end
        set1(4'b1111, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b1000) begin
            n_err++;
            $display("FAIL sweep_1111: got ov/E/F/G=%b expected 1000", {out_valid1, e1, f1, g1});
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        set1(4'b1000, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b1101) begin
            n_err++;
            $display("FAIL rst_load: got ov/E/F/G=%b expected 1101", {out_valid1, e1, f1, g1});
        end
        // assert reset mid-cycle with a valid operand set still present
        set1(4'b0111, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_async: got ov/E/F/G=%b expected 0000", {out_valid1, e1, f1, g1});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_held: got ov/E/F/G=%b expected 0000", {out_valid1, e1, f1, g1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        set1(4'b0100, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b1101) begin
            n_err++;
            $display("FAIL rst_release: got ov/E/F/G=%b expected 1101", {out_valid1, e1, f1, g1});
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        set1(4'b0110, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b1110) begin
            n_err++;
            $display("FAIL hold_load: got ov/E/F/G=%b expected 1110", {out_valid1, e1, f1, g1});
        end
        set1(4'b1110, 1'b0);
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b0110) begin
            n_err++;
            $display("FAIL hold_idle: got ov/E/F/G=%b expected 0110", {out_valid1, e1, f1, g1});
        end
        a1 = 1'bx; b1 = 1'bz; c1 = 1'bx; d1 = 1'bx;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b0110) begin
            n_err++;
            $display("FAIL hold_xin: got ov/E/F/G=%b expected 0110", {out_valid1, e1, f1, g1});
        end
    endtask

    task automatic test_latency;
        @(negedge clk);
        set1(4'b1100, 1'b1);
        @(posedge clk);
        #1;
        set1(4'b1001, 1'b1);
        #3;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b1000) begin
            n_err++;
            $display("FAIL latency_mid: got ov/E/F/G=%b expected 1000", {out_valid1, e1, f1, g1});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid1, e1, f1, g1} !== 4'b1110) begin
            n_err++;
            $display("FAIL latency_edge: got ov/E/F/G=%b expected 1110", {out_valid1, e1, f1, g1});
        end
        set1(4'b0000, 1'b0);
    endtask

    task automatic test_width4;
        logic [3:0] exp_e, exp_g;
        logic       exp_v;
        @(negedge clk);
        a4 = 4'hF; b4 = 4'h3; c4 = 4'h5; d4 = 4'h0;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid4, e4, f4, g4} !== {1'b1, 4'hC, 4'h5, 4'h9}) begin
            n_err++;
            $display("FAIL w4_vec: got ov=%b E=%h F=%h G=%h expected 1 C 5 9", out_valid4, e4, f4, g4);
        end
        exp_e = 4'hC;
        exp_g = 4'h9;
        for (int i = 0; i < 100; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            c4 = 4'($urandom); d4 = 4'($urandom);
            exp_v = ($urandom_range(3) != 0);
            in_valid4 = exp_v;
            if (exp_v) begin
                exp_e = a4 ^ b4;
                exp_g = a4 ^ b4 ^ c4 ^ d4;
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (g4 !== (e4 ^ f4) || e4 !== exp_e || g4 !== exp_g || out_valid4 !== exp_v) begin
                n_err++;
                $display("FAIL w4_rand[%0d]: got ov=%b E=%h F=%h G=%h expected ov=%b E=%h G=%h G=E^F",
                         i, out_valid4, e4, f4, g4, exp_v, exp_e, exp_g);
            end
        end
        in_valid4 = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_sweep();
        test_async_reset();
        test_hold();
        test_latency();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
